// File: rtl/load_size_ctrl_if.sv
// Load-size controller bus bundle: request channel, memory read port and
// response channel. The master modport is the surrounding datapath/memory,
// the slave modport is load_size_ctrl itself.
interface load_size_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  LS;
  logic        ls_unsigned;
  logic [31:0] addr;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] w_LS;

  modport master (
    output req_valid, LS, ls_unsigned, addr, mem_rdata, rsp_ready,
    input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_err, w_LS
  );

  modport slave (
    input  req_valid, LS, ls_unsigned, addr, mem_rdata, rsp_ready,
    output req_ready, mem_rd, mem_addr, rsp_valid, rsp_err, w_LS
  );
endinterface

// File: rtl/load_size_ctrl.sv
// load_size_ctrl: multi-cycle load unit. Accepts a load, issues one
// word-aligned read, waits MEM_LATENCY cycles, then extracts and extends the
// selected word/half/byte lane into w_LS.
// Optional feature macro: LOADSIZE_SIGN_EXT_EN (sign-extend half/byte loads
// when ls_unsigned=0). Without it, half/byte loads are always zero-extended.
//
// state | meaning
// IDLE  | ready for a request; latches request fields on req_valid
// READ  | one-cycle mem_rd strobe, latency counter loaded
// WAIT  | counting down memory latency; capture on the 1->0 step
// DONE  | rsp_valid held until rsp_ready
module load_size_ctrl #(
  parameter int unsigned MEM_LATENCY = 1  // 1..15
) (
  input logic             clk,
  input logic             reset,  // asynchronous, active low
  load_size_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  ls_q, ls_d;
  logic [31:0] addr_q, addr_d;
  logic        uns_q, uns_d;
  logic [31:0] w_ls_q, w_ls_d;
  logic        err_q, err_d;

  logic        req_illegal;
  logic        sx;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic [31:0] lane_ext;

  // Misalignment and the reserved size encoding are judged on the live request.
  assign req_illegal = (bus.LS == 2'b11) ||
                       (bus.LS == 2'b01 && bus.addr[0]) ||
                       (bus.LS == 2'b00 && bus.addr[1:0] != 2'b00);

`ifdef LOADSIZE_SIGN_EXT_EN
  assign sx = ~uns_q;
`else
  logic unused_uns;
  assign sx         = 1'b0;
  assign unused_uns = uns_q;
`endif

  assign half_lane = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  assign byte_lane = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];

  // Lane extraction and extension, based on the latched size/address.
  always_comb begin
    lane_ext = bus.mem_rdata;
    case (ls_q)
      2'b01:   lane_ext = {{16{sx & half_lane[15]}}, half_lane};
      2'b10:   lane_ext = {{24{sx & byte_lane[7]}}, byte_lane};
      default: lane_ext = bus.mem_rdata;
    endcase
  end

  // State, counter and result registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ls_q    <= 2'b00;
      addr_q  <= 32'd0;
      uns_q   <= 1'b0;
      w_ls_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ls_q    <= ls_d;
      addr_q  <= addr_d;
      uns_q   <= uns_d;
      w_ls_q  <= w_ls_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: sequencing, request latch, latency countdown, capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ls_d    = ls_q;
    addr_d  = addr_q;
    uns_d   = uns_q;
    w_ls_d  = w_ls_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ls_d   = bus.LS;
          addr_d = bus.addr;
          uns_d  = bus.ls_unsigned;
          if (req_illegal) begin
            state_d = DONE;
            err_d   = 1'b1;
            w_ls_d  = 32'd0;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        cnt_d   = 4'(MEM_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= guards against a stuck FSM if the counter were ever zero here
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          w_ls_d  = lane_ext;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_rd    = (state_q == READ);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_err   = err_q;
  assign bus.w_LS      = w_ls_q;

endmodule

// File: doc/load_size_ctrl.md
Name: load_size_ctrl

Overview:
- Multi-cycle load-side counterpart of the datapath's store-size merge unit.
- Accepts a load request, issues one word-aligned memory read, and waits a fixed memory latency.
- Extracts the word, halfword or byte lane selected by the address and zero-extends it (sign-extends when the optional feature is enabled).
- Sits between the memory port and the memory-data register that feeds register writeback.

Parameters:
- MEM_LATENCY, 1: cycles from the mem_rd cycle to valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  block can accept a request.
- LS  in  2  load size: 00 word, 01 half, 10 byte, 11 illegal.
- ls_unsigned  in  1  1 = zero-extend, 0 = sign-extend. Ignored unless LOADSIZE_SIGN_EXT_EN is defined.
- addr  in  32  byte address of the load.
- mem_rd  out  1  one-cycle memory read strobe.
- mem_addr  out  32  word-aligned read address {addr_q[31:2], 2'b00}.
- mem_rdata  in  32  memory read data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_err  out  1  illegal LS or misaligned access.
- w_LS  out  32  extended load result.

Behaviour:
- States: IDLE, READ, WAIT, DONE. A 4-bit latency counter is used in WAIT.
- Reset (asynchronous, reset low): state=IDLE, req_ready=1, mem_rd=0, mem_addr=0, rsp_valid=0, rsp_err=0, w_LS=0, counter=0, all latched request fields=0. A reset during any state aborts the transaction; the memory result is discarded.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a clock edge, latch LS, addr and ls_unsigned.
  - If LS=11, or LS=01 with addr[0]=1, or LS=00 with addr[1:0]!=0: go to DONE with rsp_err=1 and w_LS=0. No mem_rd is issued.
  - Otherwise go to READ.
- READ:
  - mem_rd=1 for exactly this cycle; mem_addr is valid.
  - req_ready=0 in every state except IDLE.
  - Load counter with MEM_LATENCY and go to WAIT.
- WAIT:
  - mem_rd=0; mem_addr is held.
  - Counter decrements each cycle.
  - At the edge where the counter goes 1→0, capture the extracted mem_rdata into w_LS, set rsp_err=0, and go to DONE.
  - Total: rsp_valid rises exactly MEM_LATENCY+1 cycles after the acceptance edge.
- Extraction, little-endian lanes:
  - Word: w_LS=mem_rdata.
  - Half: lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0], zero-extended to 32 bits.
  - Byte: lane = mem_rdata[8*addr_q[1:0] +: 8], zero-extended.
- DONE:
  - rsp_valid=1; w_LS and rsp_err are held stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid drops at the next edge and state returns to IDLE.
  - A new request cannot be accepted in that same edge; minimum request spacing is MEM_LATENCY+3 cycles.
- mem_rdata is ignored outside the capture edge.
- w_LS and rsp_err keep their last values after the handshake until the next capture or error.

Optional Feature:
- Macro LOADSIZE_SIGN_EXT_EN.
- Defined: for half and byte loads with ls_unsigned=0, the lane is sign-extended (bit 15 or bit 7 replicated). With ls_unsigned=1 the lane is zero-extended.
- Not defined: ls_unsigned is unused and half/byte loads are always zero-extended.
- Word loads are unaffected either way.

Test Plan:
- Word: MEM_LATENCY=1, LS=00, addr=0x0000_0010, mem_rdata=0xDEAD_BEEF → one mem_rd pulse with mem_addr=0x10; rsp_valid 2 cycles after acceptance; w_LS=0xDEADBEEF, rsp_err=0.
- Half and byte lanes: mem_rdata=0x8899_AABB.
  - LS=01, addr=0x22 → w_LS=0x0000_8899.
  - LS=10, addr=0x21 → w_LS=0x0000_00AA.
  - LS=10, addr=0x23 → w_LS=0x0000_0088.
- Errors: LS=01 addr=0x21; LS=00 addr=0x22; LS=11 addr=0x20 → no mem_rd; rsp_valid the next cycle with rsp_err=1 and w_LS=0.
- Backpressure: MEM_LATENCY=3, hold rsp_ready=0 for 5 cycles in DONE → rsp_valid and w_LS stable throughout, req_ready=0; release → IDLE one cycle later. A req_valid held high during DONE is not accepted until IDLE.
- Reset mid-WAIT: MEM_LATENCY=4, pull reset low 2 cycles after mem_rd → all outputs return to reset values immediately; after release, no rsp_valid appears for the aborted load.
- With LOADSIZE_SIGN_EXT_EN, ls_unsigned=0, mem_rdata=0x8899_AABB:
  - LS=10 addr=0x20 → 0xFFFF_FFBB.
  - LS=01 addr=0x20 → 0xFFFF_AABB.
  - Same with ls_unsigned=1 → 0x0000_00BB and 0x0000_AABB.
